// File: rtl/rfphoenix_insn_issue_sched_pkg.sv
// Shared types and defaults for the instruction issue scheduler.
package rfphoenix_insn_issue_sched_pkg;

  localparam int unsigned NTHREAD_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rfphoenix_rr_arb.sv
// Round-robin arbiter: first requester at or after i_ptr, wrapping modulo N (N >= 2).
module rfphoenix_rr_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_id,
  output logic          o_gnt_any
);

  int unsigned w_idx;

  always_comb begin
    o_gnt     = '0;
    o_gnt_id  = '0;
    o_gnt_any = 1'b0;
    w_idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = 32'(i_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!o_gnt_any && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_gnt_id     = IW'(w_idx);
        o_gnt_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rfphoenix_insn_issue_sched.sv
// Round-robin issue scheduler sharing one issue port among per-thread instruction FIFOs.
module rfphoenix_insn_issue_sched
  import rfphoenix_insn_issue_sched_pkg::*;
#(
  parameter int unsigned NTHREAD = NTHREAD_DEF,
  parameter int unsigned TIDW    = $clog2(NTHREAD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NTHREAD-1:0] fifo_empty,
  input  logic [NTHREAD-1:0] fifo_v,
  input  logic [NTHREAD-1:0] fifo_busy,
  input  logic [NTHREAD-1:0] thread_stall,
  input  logic [NTHREAD-1:0] flush,
  output logic [NTHREAD-1:0] fifo_rd,
  output logic               issue_valid,
  output logic [TIDW-1:0]    issue_tid,
  input  logic               issue_ready,
  output logic               underflow_err
);

  sched_state_t     r_state, w_state_nxt;
  logic [TIDW-1:0]  r_rr_ptr;
  logic [TIDW-1:0]  r_cur_tid;
  logic             r_underflow;

  logic [NTHREAD-1:0] w_elig;
  logic [NTHREAD-1:0] w_gnt;
  logic [TIDW-1:0]    w_gnt_tid;
  logic               w_gnt_any;
  logic               w_may_read;
  logic               w_grant;
  logic               w_cur_flush;
  logic               w_cur_v;
  logic               w_underflow;

  assign w_elig = ~fifo_empty & ~fifo_busy & ~thread_stall & ~flush;

  rfphoenix_rr_arb #(
    .N  (NTHREAD),
    .IW (TIDW)
  ) u_arb (
    .i_req     (w_elig),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_id  (w_gnt_tid),
    .o_gnt_any (w_gnt_any)
  );

  assign w_cur_flush = flush[r_cur_tid];
  assign w_cur_v     = fifo_v[r_cur_tid];

  always_comb begin
    issue_valid = 1'b0;
    case (r_state)
      PEND:    issue_valid = w_cur_v & ~w_cur_flush;
      HOLD:    issue_valid = ~w_cur_flush;
      default: issue_valid = 1'b0;
    endcase
  end

  // Reset also masks the read strobe so no FIFO word is consumed while the scheduler is held.
  assign w_may_read = rst_n & ((r_state == IDLE) | (issue_valid & issue_ready));
  assign w_grant    = w_may_read & w_gnt_any;
  assign fifo_rd    = w_grant ? w_gnt : '0;

  assign w_underflow = (r_state == PEND) & ~w_cur_flush & ~w_cur_v;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: w_state_nxt = w_grant ? PEND : IDLE;
      PEND: begin
        if (w_cur_flush)      w_state_nxt = w_grant ? PEND : IDLE;
        else if (!w_cur_v)    w_state_nxt = IDLE;
        else if (issue_ready) w_state_nxt = w_grant ? PEND : IDLE;
        else                  w_state_nxt = HOLD;
      end
      HOLD: begin
        if (w_cur_flush)      w_state_nxt = IDLE;
        else if (issue_ready) w_state_nxt = w_grant ? PEND : IDLE;
        else                  w_state_nxt = HOLD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_cur_tid   <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_cur_tid <= w_gnt_tid;
        r_rr_ptr  <= (32'(w_gnt_tid) == NTHREAD - 1) ? '0 : w_gnt_tid + 1'b1;
      end
      if (w_underflow) r_underflow <= 1'b1;
    end
  end

  assign issue_tid     = r_cur_tid;
  assign underflow_err = r_underflow;

endmodule

// File: tb/tb_rfphoenix_insn_issue_sched.sv
// Scoreboard bench for the issue scheduler with a behavioural model of four thread FIFOs.
module tb_rfphoenix_insn_issue_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] fifo_empty, fifo_v, fifo_busy, thread_stall, flush, fifo_rd;
  logic       issue_valid, issue_ready, underflow_err;
  logic [1:0] issue_tid;

  int         cnt [4];
  logic [3:0] withhold;
  logic [3:0] last_rd;
  logic [1:0] sb_q [$];
  int         vectors     = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  rfphoenix_insn_issue_sched #(.NTHREAD(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_v        (fifo_v),
    .fifo_busy     (fifo_busy),
    .thread_stall  (thread_stall),
    .flush         (flush),
    .fifo_rd       (fifo_rd),
    .issue_valid   (issue_valid),
    .issue_tid     (issue_tid),
    .issue_ready   (issue_ready),
    .underflow_err (underflow_err)
  );

  task automatic refresh();
    for (int i = 0; i < 4; i++) fifo_empty[i] = (cnt[i] == 0);
  endtask

  // One clock: score the current cycle, advance, then update the FIFO model.
  task automatic tick();
    logic [3:0] rd;
    logic       hs;
    logic [1:0] t;
    rd = fifo_rd;
    hs = issue_valid & issue_ready;
    vectors++;
    if ($countones(rd) > 1) begin
      miscompares++;
      $display("FAIL rd_onehot: got %b required at most one bit", rd);
    end
    if (sb_q.size() != 0 && flush[sb_q[0]]) begin
      t = sb_q.pop_front();
    end else if (sb_q.size() != 0 && last_rd != 0 && (fifo_v & last_rd) == 0) begin
      t = sb_q.pop_front();
    end else if (hs) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_accept: tid %0d accepted, required no word outstanding", issue_tid);
      end else begin
        t = sb_q.pop_front();
        if (issue_tid !== t) begin
          miscompares++;
          $display("FAIL sb_tid: got %0d expected %0d", issue_tid, t);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (rd[i]) begin
        sb_q.push_back(2'(i));
        cnt[i]--;
      end
    end
    last_rd = rd;
    @(posedge clk);
    #1;
    fifo_v = rd & ~withhold;
    refresh();
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    refresh();
    issue_ready = 1'b1;
    #1;
    repeat (3) tick();
    vectors++;
    if (issue_valid !== 1'b0 || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: valid=%b pending=%0d required valid=0 pending=0", issue_valid, sb_q.size());
    end
  endtask

  task automatic test_power_on();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cnt[i] = 1;
    refresh();
    #1;
    vectors++;
    if (issue_valid !== 1'b0 || fifo_rd !== 4'b0000 || issue_tid !== 2'd0 || underflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL por: valid=%b rd=%b tid=%0d uerr=%b required 0,0000,0,0",
               issue_valid, fifo_rd, issue_tid, underflow_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    refresh();
    #1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rd [5];
    exp_rd = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) cnt[i] = 2;
    refresh();
    issue_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (fifo_rd !== exp_rd[k]) begin
        miscompares++;
        $display("FAIL rr_rd[%0d]: got %b expected %b", k, fifo_rd, exp_rd[k]);
      end
      vectors++;
      if (issue_valid !== (k != 0)) begin
        miscompares++;
        $display("FAIL rr_valid[%0d]: got %b expected %b", k, issue_valid, (k != 0));
      end
      if (k != 0) begin
        vectors++;
        if (issue_tid !== 2'(k - 1)) begin
          miscompares++;
          $display("FAIL rr_tid[%0d]: got %0d expected %0d", k, issue_tid, k - 1);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_hold();
    issue_ready = 1'b0;
    cnt[2] = 1;
    cnt[3] = 1;
    refresh();
    #1;
    vectors++;
    if (fifo_rd !== 4'b0100) begin
      miscompares++;
      $display("FAIL hold_grant: got %b expected 0100", fifo_rd);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (issue_valid !== 1'b1 || issue_tid !== 2'd2 || fifo_rd !== 4'b0000) begin
        miscompares++;
        $display("FAIL hold[%0d]: valid=%b tid=%0d rd=%b expected 1,2,0000", k, issue_valid, issue_tid, fifo_rd);
      end
      tick();
    end
    issue_ready = 1'b1;
    #1;
    vectors++;
    if (issue_valid !== 1'b1 || issue_tid !== 2'd2 || fifo_rd !== 4'b1000) begin
      miscompares++;
      $display("FAIL hold_release: valid=%b tid=%0d rd=%b expected 1,2,1000", issue_valid, issue_tid, fifo_rd);
    end
    tick();
    vectors++;
    if (issue_valid !== 1'b1 || issue_tid !== 2'd3 || fifo_rd !== 4'b0000) begin
      miscompares++;
      $display("FAIL hold_next: valid=%b tid=%0d rd=%b expected 1,3,0000", issue_valid, issue_tid, fifo_rd);
    end
    drain();
  endtask

  task automatic test_flush();
    issue_ready = 1'b0;
    cnt[1] = 1;
    refresh();
    #1;
    vectors++;
    if (fifo_rd !== 4'b0010) begin
      miscompares++;
      $display("FAIL flush_grant: got %b expected 0010", fifo_rd);
    end
    tick();
    tick();
    vectors++;
    if (issue_valid !== 1'b1 || issue_tid !== 2'd1) begin
      miscompares++;
      $display("FAIL flush_held: valid=%b tid=%0d expected 1,1", issue_valid, issue_tid);
    end
    cnt[3] = 1;
    refresh();
    flush = 4'b0010;
    issue_ready = 1'b1;
    #1;
    vectors++;
    if (issue_valid !== 1'b0 || fifo_rd !== 4'b0000) begin
      miscompares++;
      $display("FAIL flush_kill: valid=%b rd=%b expected 0,0000", issue_valid, fifo_rd);
    end
    tick();
    flush = 4'b0000;
    #1;
    vectors++;
    if (issue_valid !== 1'b0 || fifo_rd !== 4'b1000 || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL flush_idle: valid=%b rd=%b pending=%0d expected 0,1000,0", issue_valid, fifo_rd, sb_q.size());
    end
    tick();
    drain();
  endtask

  task automatic test_stall();
    cnt[0] = 1;
    refresh();
    issue_ready = 1'b1;
    #1;
    tick();
    drain();
    thread_stall = 4'b0010;
    for (int i = 0; i < 3; i++) cnt[i] = 1;
    refresh();
    #1;
    vectors++;
    if (fifo_rd !== 4'b0100) begin
      miscompares++;
      $display("FAIL stall_first: got %b expected 0100", fifo_rd);
    end
    tick();
    vectors++;
    if (issue_valid !== 1'b1 || issue_tid !== 2'd2 || fifo_rd !== 4'b0001) begin
      miscompares++;
      $display("FAIL stall_second: valid=%b tid=%0d rd=%b expected 1,2,0001", issue_valid, issue_tid, fifo_rd);
    end
    tick();
    vectors++;
    if (issue_valid !== 1'b1 || issue_tid !== 2'd0 || fifo_rd !== 4'b0000) begin
      miscompares++;
      $display("FAIL stall_blocked: valid=%b tid=%0d rd=%b expected 1,0,0000", issue_valid, issue_tid, fifo_rd);
    end
    tick();
    thread_stall = 4'b0000;
    drain();
  endtask

  task automatic test_underflow();
    withhold = 4'b0010;
    cnt[1] = 1;
    refresh();
    issue_ready = 1'b1;
    #1;
    vectors++;
    if (fifo_rd !== 4'b0010 || underflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL uf_grant: rd=%b uerr=%b expected 0010,0", fifo_rd, underflow_err);
    end
    tick();
    vectors++;
    if (issue_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL uf_pend_valid: got %b expected 0", issue_valid);
    end
    tick();
    withhold = 4'b0000;
    cnt[2] = 1;
    refresh();
    #1;
    vectors++;
    if (underflow_err !== 1'b1 || issue_valid !== 1'b0 || fifo_rd !== 4'b0100) begin
      miscompares++;
      $display("FAIL uf_set: uerr=%b valid=%b rd=%b expected 1,0,0100", underflow_err, issue_valid, fifo_rd);
    end
    tick();
    tick();
    vectors++;
    if (underflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL uf_sticky: got %b expected 1", underflow_err);
    end
    drain();
  endtask

  task automatic test_reset();
    issue_ready = 1'b0;
    cnt[3] = 1;
    cnt[0] = 1;
    refresh();
    #1;
    vectors++;
    if (fifo_rd !== 4'b1000) begin
      miscompares++;
      $display("FAIL rst_grant: got %b expected 1000", fifo_rd);
    end
    tick();
    tick();
    vectors++;
    if (issue_valid !== 1'b1 || issue_tid !== 2'd3) begin
      miscompares++;
      $display("FAIL rst_held: valid=%b tid=%0d expected 1,3", issue_valid, issue_tid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (issue_valid !== 1'b0 || fifo_rd !== 4'b0000 || issue_tid !== 2'd0 || underflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: valid=%b rd=%b tid=%0d uerr=%b expected 0,0000,0,0",
               issue_valid, fifo_rd, issue_tid, underflow_err);
    end
    sb_q.delete();
    fifo_v  = 4'b0000;
    last_rd = 4'b0000;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    issue_ready = 1'b1;
    #1;
    vectors++;
    if (fifo_rd !== 4'b0001) begin
      miscompares++;
      $display("FAIL rst_ptr: got %b expected 0001", fifo_rd);
    end
    tick();
    drain();
  endtask

  initial begin
    rst_n        = 1'b0;
    fifo_v       = 4'b0000;
    fifo_busy    = 4'b0000;
    thread_stall = 4'b0000;
    flush        = 4'b0000;
    issue_ready  = 1'b0;
    withhold     = 4'b0000;
    last_rd      = 4'b0000;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    refresh();

    test_power_on();
    test_round_robin();
    test_hold();
    test_flush();
    test_stall();
    test_underflow();
    test_reset();

    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_final: %0d words pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
